// File: rtl/ray_pixel_generator.sv
// Raster-scan primary-ray generator with latency-matched result FIFO toward the framebuffer.
// Optional stall counter output enabled by defining RAYGEN_STALL_CNT_EN.
module ray_pixel_generator #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int COORD_W    = 10,
    parameter int FOCAL      = 320,
    parameter int CORE_LAT   = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 19
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic signed [COORD_W-1:0] pixel_x,
    output logic signed [COORD_W-1:0] pixel_y,
    output logic signed [COORD_W-1:0] pixel_z,
    output logic                      pixel_valid,
    input  logic                      core_less_than_zero,
    output logic                      fb_valid,
    input  logic                      fb_ready,
    output logic [ADDR_W-1:0]         fb_addr,
    output logic                      fb_hit
`ifdef RAYGEN_STALL_CNT_EN
    ,
    output logic [31:0]               stall_cycles
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W = $clog2(CORE_LAT + 2);

    logic [1:0]        state;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] pix_addr;
    logic [CORE_LAT-1:0] sr_vld;
    logic [ADDR_W-1:0] sr_addr [CORE_LAT];
    logic [ADDR_W:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic [INF_W-1:0]  inflight;
    logic              issue;
    logic              last_pix;
    logic              push;
    logic              pop;
    logic              fifo_empty;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // The ray sitting on pixel_* has been issued but is not yet in the shift register.
    always_comb begin
        inflight = INF_W'(pixel_valid);
        for (int i = 0; i < CORE_LAT; i++) begin
            inflight = inflight + INF_W'(sr_vld[i]);
        end
    end

    assign last_pix   = (col == COL_W'(H_RES - 1)) && (row == ROW_W'(V_RES - 1));
    assign issue      = (state == S_SCAN) && ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);
    assign fifo_empty = (fifo_count == '0);
    assign push       = sr_vld[CORE_LAT-1];
    assign pop        = fb_valid && fb_ready;
    assign fb_valid   = !fifo_empty;
    assign {fb_addr, fb_hit} = fifo_empty ? '0 : fifo_mem[rd_ptr];
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DRAIN) && (inflight == '0) && fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            col   <= '0;
            row   <= '0;
            addr  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_SCAN;
                        col   <= '0;
                        row   <= '0;
                        addr  <= '0;
                    end
                end
                S_SCAN: begin
                    if (issue) begin
                        addr <= addr + 1'b1;
                        if (col == COL_W'(H_RES - 1)) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        if (last_pix) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (done) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Issue stage: ray components and their address register together.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_valid <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            pixel_z     <= '0;
            pix_addr    <= '0;
        end else begin
            pixel_valid <= issue;
            if (issue) begin
                pixel_x  <= COORD_W'(col) - COORD_W'(H_RES / 2);
                pixel_y  <= COORD_W'(V_RES / 2 - 1) - COORD_W'(row);
                pixel_z  <= COORD_W'(FOCAL);
                pix_addr <= addr;
            end
        end
    end

    // Alignment stages: tail lines up with the core result for the same ray.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_vld <= '0;
        end else begin
            sr_vld[0] <= pixel_valid;
            for (int i = 1; i < CORE_LAT; i++) sr_vld[i] <= sr_vld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        sr_addr[0] <= pix_addr;
        for (int i = 1; i < CORE_LAT; i++) sr_addr[i] <= sr_addr[i-1];
    end

    // Result FIFO: push from the alignment tail, pop on the framebuffer handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            assert (!(push && !pop && fifo_count == CNT_W'(FIFO_DEPTH)));
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {sr_addr[CORE_LAT-1], ~core_less_than_zero};
    end

`ifdef RAYGEN_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (state == S_IDLE && start) begin
            stall_cycles <= '0;
        end else if (state == S_SCAN && !issue && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ray_pixel_generator.sv
// Bench for ray_pixel_generator on a 4x2 screen with a 3-cycle delay core model.
// Covers RAYGEN_STALL_CNT_EN when that macro is defined for the build.
module tb_ray_pixel_generator;

    localparam int H   = 4;
    localparam int V   = 2;
    localparam int FOC = 8;
    localparam int LAT = 3;
    localparam int NPX = H * V;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              busy;
    logic              done;
    logic signed [9:0] pixel_x;
    logic signed [9:0] pixel_y;
    logic signed [9:0] pixel_z;
    logic              pixel_valid;
    logic              core_ltz;
    logic              fb_valid;
    logic              fb_ready = 1'b1;
    logic [2:0]        fb_addr;
    logic              fb_hit;
`ifdef RAYGEN_STALL_CNT_EN
    logic [31:0]       stall_cycles;
`endif

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int done_cnt  = 0;
    int done_cyc  = 0;
    int rx[$], ry[$], rz[$], wa[$], wh[$];

    ray_pixel_generator #(
        .H_RES(H), .V_RES(V), .COORD_W(10), .FOCAL(FOC),
        .CORE_LAT(LAT), .FIFO_DEPTH(8), .ADDR_W(3)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_z(pixel_z),
        .pixel_valid(pixel_valid), .core_less_than_zero(core_ltz),
        .fb_valid(fb_valid), .fb_ready(fb_ready), .fb_addr(fb_addr), .fb_hit(fb_hit)
`ifdef RAYGEN_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: miss when |x| > 1, three cycles after pixel_* changes.
    logic c1 = 1'b0, c2 = 1'b0, c3 = 1'b0;
    always @(posedge clk) begin
        c1 <= (pixel_x > 1) || (pixel_x < -1);
        c2 <= c1;
        c3 <= c2;
    end
    assign core_ltz = c3;

    always @(negedge clk) begin
        if (pixel_valid) begin
            rx.push_back(int'(pixel_x));
            ry.push_back(int'(pixel_y));
            rz.push_back(int'(pixel_z));
        end
        if (fb_valid && fb_ready) begin
            wa.push_back(int'(fb_addr));
            wh.push_back(int'(fb_hit));
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    function automatic int exp_x(input int a);
        return (a % H) - H / 2;
    endfunction
    function automatic int exp_y(input int a);
        return V / 2 - 1 - a / H;
    endfunction
    function automatic int exp_hit(input int a);
        int x = exp_x(a);
        return (x > 1 || x < -1) ? 0 : 1;
    endfunction
    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -999;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        rx.delete(); ry.delete(); rz.delete(); wa.delete(); wh.delete();
    endtask

    task automatic pulse_start(output int s_cyc);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        s_cyc = cyc;
    endtask

    task automatic wait_done(input string tag, input int base, input int budget);
        int n = 0;
        while (done_cnt == base && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, int'(done_cnt != base), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_nwrites"}, wa.size(), NPX);
        for (int i = 0; i < NPX; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), qget(wa, i), i);
            chk($sformatf("%s_hit%0d", tag, i), qget(wh, i), exp_hit(i));
        end
    endtask

    initial begin
        int s, base;

        // Reset and idle outputs
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fb_valid", fb_valid, 0);
        chk("rst_pixel_valid", pixel_valid, 0);
        chk("rst_pixel_x", pixel_x, 0);
        chk("rst_pixel_y", pixel_y, 0);
        chk("rst_pixel_z", pixel_z, 0);
        clear_q();

        // Full-rate frame
        fb_ready = 1'b1;
        base = done_cnt;
        pulse_start(s);
        wait_done("s2", base, 100);
        chk("s2_done_latency", done_cyc - s, NPX + LAT + 2);
        chk("s2_done_count", done_cnt - base, 1);
        chk("s2_nrays", rx.size(), NPX);
        for (int i = 0; i < NPX; i++) begin
            chk($sformatf("s2_ray%0d_x", i), qget(rx, i), exp_x(i));
            chk($sformatf("s2_ray%0d_y", i), qget(ry, i), exp_y(i));
            chk($sformatf("s2_ray%0d_z", i), qget(rz, i), FOC);
        end
        check_frame("s2");
`ifdef RAYGEN_STALL_CNT_EN
        chk("s2_stall_cycles", stall_cycles, 0);
`endif
        clear_q();

        // Consumer stalled for the whole scan, then released
        fb_ready = 1'b0;
        base = done_cnt;
        pulse_start(s);
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("s3_nrays", rx.size(), NPX);
        chk("s3_pixel_valid", pixel_valid, 0);
        chk("s3_fb_valid", fb_valid, 1);
        chk("s3_head_addr", fb_addr, 0);
        chk("s3_busy", busy, 1);
        chk("s3_no_done", done_cnt - base, 0);
        chk("s3_no_writes", wa.size(), 0);
`ifdef RAYGEN_STALL_CNT_EN
        // Eight pixels fit the eight credits, so SCAN never runs dry at this size.
        chk("s3_stall_cycles", stall_cycles, 0);
`endif
        @(posedge clk); #1 fb_ready = 1'b1;
        wait_done("s3", base, 100);
        chk("s3_done_count", done_cnt - base, 1);
        check_frame("s3");
        clear_q();

        // Alternating ready
        base = done_cnt;
        pulse_start(s);
        begin
            int n = 0;
            while (done_cnt == base && n < 200) begin
                @(posedge clk);
                #1 fb_ready = ~fb_ready;
                n++;
            end
        end
        chk("s4_done_seen", int'(done_cnt != base), 1);
        fb_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("s4_done_count", done_cnt - base, 1);
        check_frame("s4");
        clear_q();

        // Start during SCAN is ignored; a later start restarts at address 0
        base = done_cnt;
        pulse_start(s);
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done("s5", base, 100);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("s5_done_count", done_cnt - base, 1);
        chk("s5_busy_after", busy, 0);
        check_frame("s5a");
        clear_q();
        base = done_cnt;
        pulse_start(s);
        wait_done("s5b", base, 100);
        check_frame("s5b");
        clear_q();

        // Reset while addr 3 is being issued
        base = done_cnt;
        pulse_start(s);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("s6_fb_valid", fb_valid, 0);
        chk("s6_busy", busy, 0);
        chk("s6_pixel_valid", pixel_valid, 0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("s6_no_done", done_cnt - base, 0);
        chk("s6_no_writes", wa.size(), 0);
        chk("s6_fb_valid_late", fb_valid, 0);
        clear_q();
        pulse_start(s);
        wait_done("s6", base, 100);
        chk("s6_done_count", done_cnt - base, 1);
        check_frame("s6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
